// File: rtl/paralelo_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : paralelo_serial_tx
// Function : Byte-to-serial transmitter, MSB first, with post-reset idle
//            training frames before payload is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module paralelo_serial_tx #(
    parameter int         TRAIN_FRAMES = 4,
    parameter logic [7:0] IDLE_SYMBOL  = 8'hBC
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_paralelo_serial,
    output logic       frame_start,
    output logic       tx_active
);

    localparam logic [3:0] c_LAST_TRAIN = 4'(TRAIN_FRAMES - 1);

    typedef enum logic [0:0] {
        S_TRAIN = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_frame;
    logic [3:0] w_frame_next;
    logic [2:0] r_bit;
    logic [7:0] r_shift;
    logic       r_dout;
    logic       r_frame_start;
    logic       r_started;

    logic       w_frame_end;
    logic       w_load;
    logic       w_accept;
    logic [7:0] w_byte;

    // r_started distinguishes the reset-release edge, which loads frame 0.
    assign w_frame_end = (r_bit == 3'd7);
    assign w_load      = w_frame_end || !r_started;
    assign ready_out   = w_frame_end &&
                         ((r_state == S_RUN) || (r_frame == c_LAST_TRAIN));
    assign w_accept    = ready_out && valid_in;
    assign w_byte      = w_accept ? data_in : IDLE_SYMBOL;

    assign data_paralelo_serial = r_dout;
    assign frame_start          = r_frame_start;
    assign tx_active            = (r_state == S_RUN);

    always_comb begin
        w_state_next = r_state;
        w_frame_next = r_frame;
        if (r_state == S_TRAIN && w_frame_end) begin
            if (r_frame == c_LAST_TRAIN) begin
                w_state_next = S_RUN;
            end else if (r_frame != 4'hF) begin
                w_frame_next = r_frame + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            r_state       <= S_TRAIN;
            r_frame       <= 4'd0;
            r_bit         <= 3'd0;
            r_shift       <= 8'd0;
            r_dout        <= 1'b0;
            r_frame_start <= 1'b0;
            r_started     <= 1'b0;
        end else begin
            r_started <= 1'b1;
            r_state   <= w_state_next;
            r_frame   <= w_frame_next;
            r_bit     <= r_started ? (r_bit + 3'd1) : 3'd0;
            // Bit 7 goes straight to the output register; the rest queue behind it.
            if (w_load) begin
                r_dout        <= w_byte[7];
                r_shift       <= {w_byte[6:0], 1'b0};
                r_frame_start <= 1'b1;
            end else begin
                r_dout        <= r_shift[7];
                r_shift       <= {r_shift[6:0], 1'b0};
                r_frame_start <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/paralelo_serial_tx.md
PARALELO_SERIAL_TX -- requirements
Module: paralelo_serial_tx

Interface
REQ-001 The block SHALL have parameter TRAIN_FRAMES, default 4: number of forced idle frames after reset before payload may be sent (legal range 1..15).
REQ-002 The block SHALL have parameter IDLE_SYMBOL, default 8'hBC: byte sent when no payload is available.
REQ-003 The block SHALL have port clk_32f  input  1  bit clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 The block SHALL have port data_in  input  8  payload byte from the upstream 32-to-8 stage.
REQ-006 The block SHALL have port valid_in  input  1  data_in holds a valid byte.
REQ-007 The block SHALL have port ready_out  output  1  byte is accepted on the edge ending this cycle if valid_in=1.
REQ-008 The block SHALL have port data_paralelo_serial  output  1  serial bit stream, MSB first, one bit per cycle.
REQ-009 The block SHALL have port frame_start  output  1  high in the cycle carrying bit 7 of every frame.
REQ-010 The block SHALL have port tx_active  output  1  training complete; link may carry payload.

Function
REQ-011 Cycle numbering: cycle 0 is the first cycle after the first clk_32f edge that samples reset=1; frame f occupies cycles 8f..8f+7.
REQ-012 The block SHALL hold a 3-bit bit counter: 0 in cycle 8f, +1 per cycle, 7->0 wrap with no idle cycle between frames.
REQ-013 The block SHALL register data_paralelo_serial from an 8-bit shift register; cycle 8f+k carries bit (7-k) of frame f.
REQ-014 Frame 0 SHALL be loaded with IDLE_SYMBOL on the reset-release edge.
REQ-015 The state machine SHALL have two states: TRAIN (after reset, tx_active=0) and RUN (tx_active=1).
REQ-016 In TRAIN, a saturating frame counter SHALL count completed frames; TRAIN->RUN occurs on the edge ending frame TRAIN_FRAMES-1.
REQ-017 RUN SHALL be left only by reset.
REQ-018 ready_out SHALL be high only when bit counter=7 and either (state=RUN) or (state=TRAIN and current frame is TRAIN_FRAMES-1); ready_out is combinational from registered state.
REQ-019 The shift register SHALL load data_in on the edge ending a cycle with ready_out=1 and valid_in=1; otherwise it loads IDLE_SYMBOL.
REQ-020 Latency: an accepted byte's MSB SHALL appear in the cycle immediately after acceptance and its LSB 7 cycles later.
REQ-021 valid_in while ready_out=0 SHALL be ignored and nothing is buffered; upstream holds the byte until accepted.
REQ-022 Frames 0..TRAIN_FRAMES-1 SHALL always be IDLE_SYMBOL regardless of valid_in.
REQ-023 Back-to-back accepted bytes SHALL be sent in consecutive frames with no idle gap.
REQ-024 A payload byte equal to IDLE_SYMBOL SHALL be sent unchanged (no escaping).
REQ-025 X on data_in while valid_in=0 SHALL NOT propagate to data_paralelo_serial.

Reset
REQ-026 While reset=0 at an edge: data_paralelo_serial=0, frame_start=0, tx_active=0, ready_out=0, bit counter=0, frame counter=0, state=TRAIN, shift register=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame at the next edge with no partial completion; after release, training restarts from frame 0 per REQ-014.

Verification
REQ-028 Reset release, valid_in=0 -> cycles 0-31 = 10111100 x4, frame_start at cycles 0/8/16/24, ready_out first high at cycle 31, tx_active=1 from cycle 32, BC continues.
REQ-029 valid_in=1, data_in=8'hA5 held from cycle 0 -> accepted only at end of cycle 31; cycles 32-39 = 1,0,1,0,0,1,0,1.
REQ-030 Bytes 8'h01 then 8'h80, each presented when ready_out=1 at cycles 31 and 39 -> cycles 32-47 = 00000001 10000000 with no gap.
REQ-031 valid_in=0 at cycle 39 after one accepted byte -> frame 5 (cycles 40-47) = 10111100.
REQ-032 reset=0 at cycle 35 for 3 cycles -> outputs 0 from the next edge; after release 4 BC frames, tx_active=0 until new cycle 32.
REQ-033 TRAIN_FRAMES=1 -> ready_out first high at cycle 7, tx_active=1 from cycle 8; a byte presented at cycle 7 appears in cycles 8-15.
